// File: rtl/multi_channel_gain_mixer_if.sv
// Channel-side bundle of the gain mixer: per-channel samples, enables and gain
// targets in; frame handshake, mixed sample and current gains out.
interface multi_channel_gain_mixer_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8,
   parameter int GAIN_W = 8
);
   logic [NUM_CH*DATA_W-1:0] sample_in;
   logic [NUM_CH-1:0]        ch_enable;
   logic [NUM_CH*GAIN_W-1:0] gain_target;
   logic                     mute;
   logic                     start;
   logic                     busy;
   logic [DATA_W-1:0]        mix_out;
   logic                     mix_valid;
   logic                     clip;
   logic [NUM_CH*GAIN_W-1:0] gain_cur;

   modport master (
      output sample_in, ch_enable, gain_target, mute, start,
      input  busy, mix_out, mix_valid, clip, gain_cur
   );

   modport slave (
      input  sample_in, ch_enable, gain_target, mute, start,
      output busy, mix_out, mix_valid, clip, gain_cur
   );
endinterface

// File: rtl/multi_channel_gain_mixer.sv
// NUM_CH-channel unsigned mixer with per-channel slewed gains and a single
// time-multiplexed multiplier. One saturated sample is produced per start.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for start; inputs and gains snapshotted on start
//   S_MAC  | one channel per cycle accumulated into acc
//   S_OUT  | mix_out/clip/mix_valid presented; busy drops next cycle
module multi_channel_gain_mixer #(
   parameter int NUM_CH    = 4,
   parameter int DATA_W    = 8,
   parameter int GAIN_W    = 8,
   parameter int SLEW_DIV  = 2048,
   parameter int SLEW_STEP = 1
) (
   input logic                        clk,
   input logic                        rst,
   multi_channel_gain_mixer_if.slave  bus
);

   localparam int DIV_W  = $clog2(SLEW_DIV);
   localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int ACC_W  = DATA_W + $clog2(NUM_CH) + 1;
   localparam int PROD_W = DATA_W + GAIN_W + 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLEW_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
   localparam logic [ACC_W-1:0] OUT_MAX  = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

   state_t            state;
   logic [DIV_W-1:0]  div_cnt;
   logic              slew_tick;
   logic [GAIN_W-1:0] gain_r [NUM_CH];

   logic [DATA_W-1:0] samp_q [NUM_CH];
   logic [GAIN_W-1:0] gain_q [NUM_CH];
   logic [NUM_CH-1:0] en_q;
   logic [IDX_W-1:0]  idx;
   logic [ACC_W-1:0]  acc;

   logic              busy_r;
   logic [DATA_W-1:0] mix_out_r;
   logic              mix_valid_r;
   logic              clip_r;

   logic [DATA_W-1:0] mac_samp;
   logic [GAIN_W-1:0] mac_gain;
   logic [GAIN_W:0]   mac_geff;
   logic [PROD_W-1:0] mac_prod;
   logic [DATA_W-1:0] mac_term;
   logic [ACC_W-1:0]  acc_next;

   // Move cur toward tgt by at most SLEW_STEP, landing exactly on tgt.
   function automatic logic [GAIN_W-1:0] slew_next(input logic [GAIN_W-1:0] cur,
                                                   input logic [GAIN_W-1:0] tgt);
      int c;
      int t;
      int d;
      c = int'(cur);
      t = int'(tgt);
      if (c < t) begin
         d = t - c;
         c = c + ((d < SLEW_STEP) ? d : SLEW_STEP);
      end else begin
         d = c - t;
         c = c - ((d < SLEW_STEP) ? d : SLEW_STEP);
      end
      return GAIN_W'(c);
   endfunction

   assign slew_tick = (div_cnt == DIV_LAST);

   // Free-running slew divider, wraps after SLEW_DIV clocks.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (slew_tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Gain slewing runs independently of the frame FSM and channel enables.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_CH; k++) gain_r[k] <= '0;
      end else if (slew_tick) begin
         for (int k = 0; k < NUM_CH; k++) begin
            gain_r[k] <= slew_next(gain_r[k],
                                   bus.mute ? '0 : bus.gain_target[k*GAIN_W +: GAIN_W]);
         end
      end
   end

   // Shared multiplier; all-ones gain is treated as exact unity (2^GAIN_W).
   always_comb begin
      mac_samp = samp_q[idx];
      mac_gain = gain_q[idx];
      mac_geff = (&mac_gain) ? {1'b1, {GAIN_W{1'b0}}} : {1'b0, mac_gain};
      mac_prod = PROD_W'(mac_samp) * PROD_W'(mac_geff);
      mac_term = DATA_W'(mac_prod >> GAIN_W);
      acc_next = acc + (en_q[idx] ? ACC_W'(mac_term) : '0);
   end

   // Frame sequencer: snapshot, accumulate one channel per cycle, saturate.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         idx         <= '0;
         acc         <= '0;
         en_q        <= '0;
         busy_r      <= 1'b0;
         mix_out_r   <= '0;
         mix_valid_r <= 1'b0;
         clip_r      <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            samp_q[k] <= '0;
            gain_q[k] <= '0;
         end
      end else begin
         mix_valid_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  for (int k = 0; k < NUM_CH; k++) begin
                     samp_q[k] <= bus.sample_in[k*DATA_W +: DATA_W];
                     gain_q[k] <= gain_r[k];
                  end
                  en_q   <= bus.ch_enable;
                  idx    <= '0;
                  acc    <= '0;
                  busy_r <= 1'b1;
                  state  <= S_MAC;
               end
            end
            S_MAC: begin
               acc <= acc_next;
               // Result is registered on the last MAC edge so it is visible in S_OUT.
               if (idx == IDX_LAST) begin
                  mix_out_r   <= (acc_next > OUT_MAX) ? {DATA_W{1'b1}} : DATA_W'(acc_next);
                  clip_r      <= (acc_next > OUT_MAX);
                  mix_valid_r <= 1'b1;
                  state       <= S_OUT;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            S_OUT: begin
               busy_r <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               busy_r <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_gain_out
      assign bus.gain_cur[k*GAIN_W +: GAIN_W] = gain_r[k];
   end

   assign bus.busy      = busy_r;
   assign bus.mix_out   = mix_out_r;
   assign bus.mix_valid = mix_valid_r;
   assign bus.clip      = clip_r;

endmodule
